// File: rtl/iir1_pkg.sv
// iir1_pkg: shared widths, FSM state encoding and sample types for the
// first-order IIR filter family (iir1 and its inverse iir1_inv).
// Contents:
//   X_W, Y_W, FRAC_SH, P_W   sample/coefficient widths and feedback shift
//   iir1_inv_state_t         IDLE/CALC/DIV/OUT state encoding
//   x_t, y_t, q_t            signed sample and wide-quotient types
//   mag_y, mag_x             two's-complement magnitude helpers
package iir1_pkg;

  localparam int X_W     = 4;
  localparam int Y_W     = 8;
  localparam int FRAC_SH = 4;
  localparam int P_W     = 12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DIV  = 2'd2,
    OUT  = 2'd3
  } iir1_inv_state_t;

  typedef logic signed [X_W-1:0] x_t;
  typedef logic signed [Y_W-1:0] y_t;
  // One bit wider than y_t so +128 (-128 / -1 style results) is representable.
  typedef logic signed [Y_W:0]   q_t;

  // Magnitude of a signed output sample; -128 maps to unsigned 128.
  function automatic logic [Y_W-1:0] mag_y(input logic signed [Y_W-1:0] v);
    logic [Y_W-1:0] m;
    if (v[Y_W-1]) m = ~v + {{(Y_W-1){1'b0}}, 1'b1};
    else          m = v;
    return m;
  endfunction

  // Magnitude of a signed coefficient; -8 maps to unsigned 8.
  function automatic logic [X_W-1:0] mag_x(input logic signed [X_W-1:0] v);
    logic [X_W-1:0] m;
    if (v[X_W-1]) m = ~v + {{(X_W-1){1'b0}}, 1'b1};
    else          m = v;
    return m;
  endfunction

endpackage

// File: rtl/iir1_sdiv.sv
// iir1_sdiv: sequential signed divider, restoring algorithm, one quotient bit
// per clock over Y_W iterations. Quotient truncates toward zero; the
// remainder is discarded. The divisor must be non-zero when started.
// Ports:
//   i_clk, i_rst_n   clock, synchronous active-low reset
//   i_start          load operands (one-cycle pulse)
//   i_dividend       signed Y_W-bit dividend
//   i_divisor        signed X_W-bit divisor
//   o_done           high during the cycle whose closing edge is the last iteration
//   o_quotient       signed Y_W+1-bit quotient, valid while o_done is high
module iir1_sdiv
  import iir1_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic signed [Y_W-1:0] i_dividend,
  input  logic signed [X_W-1:0] i_divisor,
  output logic                  o_done,
  output logic signed [Y_W:0]   o_quotient
);

  localparam int CNT_W = $clog2(Y_W);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(Y_W - 1);

  logic             r_busy;
  logic [CNT_W-1:0] r_cnt;
  logic [Y_W-1:0]   r_dvd;   // remaining dividend bits, MSB first
  logic [X_W-2:0]   r_rem;   // partial remainder, always < |divisor| <= 8
  logic [Y_W-1:0]   r_q;
  logic [X_W-1:0]   r_dmag;
  logic             r_neg;

  logic [X_W-1:0]   w_shift;
  logic             w_ge;
  logic [X_W-2:0]   w_rem_nxt;
  logic [Y_W-1:0]   w_q_nxt;
  logic [Y_W:0]     w_q_ext;

  // One restoring step. The true difference fits X_W-1 bits, so mod-8
  // subtraction of the low bits yields it exactly (also for |divisor| = 8).
  assign w_shift   = {r_rem, r_dvd[Y_W-1]};
  assign w_ge      = (w_shift >= r_dmag);
  assign w_rem_nxt = w_ge ? (w_shift[X_W-2:0] - r_dmag[X_W-2:0]) : w_shift[X_W-2:0];
  assign w_q_nxt   = {r_q[Y_W-2:0], w_ge};
  assign o_done    = r_busy && (r_cnt == LAST);

  // Apply the result sign to the final-iteration quotient.
  always_comb begin
    w_q_ext = {1'b0, w_q_nxt};
    if (r_neg) o_quotient = ~w_q_ext + {{Y_W{1'b0}}, 1'b1};
    else       o_quotient = w_q_ext;
  end

  // Operand capture and iteration sequencing.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
      r_dvd  <= '0;
      r_rem  <= '0;
      r_q    <= '0;
      r_dmag <= '0;
      r_neg  <= 1'b0;
    end else if (i_start) begin
      r_busy <= 1'b1;
      r_cnt  <= '0;
      r_dvd  <= mag_y(i_dividend);
      r_rem  <= '0;
      r_q    <= '0;
      r_dmag <= mag_x(i_divisor);
      r_neg  <= i_dividend[Y_W-1] ^ i_divisor[X_W-1];
    end else if (r_busy) begin
      r_rem <= w_rem_nxt;
      r_dvd <= {r_dvd[Y_W-2:0], 1'b0};
      r_q   <= w_q_nxt;
      r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      if (r_cnt == LAST) r_busy <= 1'b0;
    end
  end

endmodule

// File: rtl/iir1_inv.sv
// iir1_inv: inverse of the first-order IIR filter iir1. Reconstructs
// x[n] = (y[n] - b1*x[n-1] - ((a1*y[n-1]) >>> FRAC_SH)) / b0
// with iir1's mod-2^Y_W wrap arithmetic, a sequential divider, saturation
// to the X_W range, and a divide-by-zero flag.
// Ports:
//   i_clk, i_rst_n          clock, synchronous active-low reset
//   i_y_in, i_y_valid       filter output sample in (signed), valid
//   o_y_ready               sample accepted when high (IDLE only)
//   i_b0, i_b1, i_a1        signed coefficients, captured with the sample
//   o_x_out, o_x_valid      reconstructed sample (signed), valid
//   i_x_ready               downstream accepts o_x_out
//   o_x_sat                 o_x_out was clipped
//   o_div_err               b0 was zero for this sample, o_x_out forced 0
module iir1_inv
  import iir1_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic signed [Y_W-1:0] i_y_in,
  input  logic                  i_y_valid,
  output logic                  o_y_ready,
  input  logic signed [X_W-1:0] i_b0,
  input  logic signed [X_W-1:0] i_b1,
  input  logic signed [X_W-1:0] i_a1,
  output logic signed [X_W-1:0] o_x_out,
  output logic                  o_x_valid,
  input  logic                  i_x_ready,
  output logic                  o_x_sat,
  output logic                  o_div_err
);

  localparam logic signed [Y_W:0]   Q_MAX = {{(Y_W-X_W+2){1'b0}}, {(X_W-1){1'b1}}};
  localparam logic signed [Y_W:0]   Q_MIN = {{(Y_W-X_W+2){1'b1}}, {(X_W-1){1'b0}}};
  localparam logic signed [X_W-1:0] X_MAX = {1'b0, {(X_W-1){1'b1}}};
  localparam logic signed [X_W-1:0] X_MIN = {1'b1, {(X_W-1){1'b0}}};

  iir1_inv_state_t r_state;
  y_t r_y, r_y_prev;
  x_t r_b0, r_b1, r_a1, r_x_prev;
  x_t r_x_out;
  logic r_x_valid, r_x_sat, r_div_err;

  logic signed [P_W-1:0] w_a1_ext, w_yp_ext, w_p;
  logic signed [Y_W-1:0] w_b1_ext, w_xp_ext, w_bx, w_f, w_res;
  logic                  w_div_start, w_div_done;
  q_t                    w_quo;
  logic                  w_sat_hi, w_sat_lo;
  x_t                    w_x_clip;

  // Residual in Y_W-bit wrap arithmetic, bit-matching the forward filter.
  assign w_a1_ext = {{(P_W-X_W){r_a1[X_W-1]}}, r_a1};
  assign w_yp_ext = {{(P_W-Y_W){r_y_prev[Y_W-1]}}, r_y_prev};
  assign w_p      = w_a1_ext * w_yp_ext;
  assign w_f      = Y_W'(w_p >>> FRAC_SH);
  assign w_b1_ext = {{(Y_W-X_W){r_b1[X_W-1]}}, r_b1};
  assign w_xp_ext = {{(Y_W-X_W){r_x_prev[X_W-1]}}, r_x_prev};
  assign w_bx     = w_b1_ext * w_xp_ext;
  assign w_res    = r_y - w_bx - w_f;

  // Divider runs only when b0 is non-zero; start is issued from CALC.
  assign w_div_start = (r_state == CALC) && (r_b0 != {X_W{1'b0}});

  iir1_sdiv u_div (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_start    (w_div_start),
    .i_dividend (w_res),
    .i_divisor  (r_b0),
    .o_done     (w_div_done),
    .o_quotient (w_quo)
  );

  assign w_sat_hi = (w_quo > Q_MAX);
  assign w_sat_lo = (w_quo < Q_MIN);

  // Clip the wide quotient into the X_W output range.
  always_comb begin
    w_x_clip = w_quo[X_W-1:0];
    if (w_sat_hi)      w_x_clip = X_MAX;
    else if (w_sat_lo) w_x_clip = X_MIN;
    else               w_x_clip = w_quo[X_W-1:0];
  end

  assign o_y_ready = (r_state == IDLE) && i_rst_n;
  assign o_x_out   = r_x_out;
  assign o_x_valid = r_x_valid;
  assign o_x_sat   = r_x_sat;
  assign o_div_err = r_div_err;

  // Sample sequencing FSM with registered outputs and history update.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state   <= IDLE;
      r_y       <= '0;
      r_b0      <= '0;
      r_b1      <= '0;
      r_a1      <= '0;
      r_x_prev  <= '0;
      r_y_prev  <= '0;
      r_x_out   <= '0;
      r_x_valid <= 1'b0;
      r_x_sat   <= 1'b0;
      r_div_err <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_y_valid) begin
            r_y     <= i_y_in;
            r_b0    <= i_b0;
            r_b1    <= i_b1;
            r_a1    <= i_a1;
            r_state <= CALC;
          end
        end
        CALC: begin
          if (r_b0 == {X_W{1'b0}}) begin
            r_x_out   <= '0;
            r_x_sat   <= 1'b0;
            r_div_err <= 1'b1;
            r_x_valid <= 1'b1;
            r_state   <= OUT;
          end else begin
            r_state <= DIV;
          end
        end
        DIV: begin
          if (w_div_done) begin
            r_x_out   <= w_x_clip;
            r_x_sat   <= w_sat_hi | w_sat_lo;
            r_div_err <= 1'b0;
            r_x_valid <= 1'b1;
            r_state   <= OUT;
          end
        end
        OUT: begin
          if (i_x_ready) begin
            r_x_valid <= 1'b0;
            r_x_prev  <= r_div_err ? {X_W{1'b0}} : r_x_out;
            r_y_prev  <= r_y;
            r_state   <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iir1_inv.sv
module tb_iir1_inv;

  logic              clk = 1'b0;
  logic              rst_n;
  logic signed [7:0] y_in;
  logic              y_valid;
  logic              y_ready;
  logic signed [3:0] b0, b1, a1;
  logic signed [3:0] x_out;
  logic              x_valid;
  logic              x_ready;
  logic              x_sat;
  logic              div_err;

  typedef struct {
    logic signed [3:0] x;
    logic              sat;
    logic              err;
    int                lat;
    int                acc;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   errors   = 0;
  int   cyc      = 0;
  int   last_acc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  iir1_inv dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_y_in    (y_in),
    .i_y_valid (y_valid),
    .o_y_ready (y_ready),
    .i_b0      (b0),
    .i_b1      (b1),
    .i_a1      (a1),
    .o_x_out   (x_out),
    .o_x_valid (x_valid),
    .i_x_ready (x_ready),
    .o_x_sat   (x_sat),
    .o_div_err (div_err)
  );

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Drive one sample, hold until accepted, then push its expected result.
  task automatic send(input logic signed [7:0] y, input logic signed [3:0] cb0,
                      input logic signed [3:0] cb1, input logic signed [3:0] ca1,
                      input logic signed [3:0] ex, input logic es, input logic ee,
                      input bit push);
    bit   acc;
    exp_t e;
    acc = 1'b0;
    y_in = y; b0 = cb0; b1 = cb1; a1 = ca1; y_valid = 1'b1;
    for (int n = 0; n < 200 && !acc; n++) begin
      @(negedge clk);
      if (y_ready) begin
        last_acc = cyc + 1;
        acc = 1'b1;
      end
      @(posedge clk); #1;
    end
    y_valid = 1'b0;
    if (!acc) begin
      checks++; errors++;
      $display("FAIL send_timeout: got no accept expected accept of y=%0d", y);
    end else if (push) begin
      e.x = ex; e.sat = es; e.err = ee; e.lat = ee ? 1 : 9; e.acc = last_acc;
      q.push_back(e);
    end
  endtask

  task automatic sv(input logic signed [7:0] y, input logic signed [3:0] cb0,
                    input logic signed [3:0] cb1, input logic signed [3:0] ca1,
                    input logic signed [3:0] ex, input logic es, input logic ee);
    send(y, cb0, cb1, ca1, ex, es, ee, 1'b1);
  endtask

  task automatic drain();
    for (int n = 0; n < 100 && q.size() != 0; n++) @(negedge clk);
    if (q.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst_n = 1'b0;
    @(negedge clk);
    chk("y_ready_in_reset", int'(y_ready), 0);
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic scen1();
    sv(8'sd0,  4'sd3, 4'sd0, 4'sd4, 4'sd0, 1'b0, 1'b0);
    sv(8'sd0,  4'sd3, 4'sd0, 4'sd4, 4'sd0, 1'b0, 1'b0);
    sv(8'sd15, 4'sd3, 4'sd0, 4'sd4, 4'sd5, 1'b0, 1'b0);
    sv(8'sd18, 4'sd3, 4'sd0, 4'sd4, 4'sd5, 1'b0, 1'b0);
    sv(8'sd19, 4'sd3, 4'sd0, 4'sd4, 4'sd5, 1'b0, 1'b0);
    sv(8'sd19, 4'sd3, 4'sd0, 4'sd4, 4'sd5, 1'b0, 1'b0);
  endtask

  // Scoreboard monitor: latency on x_valid rise, data on handshake.
  initial begin
    bit   pv;
    exp_t e;
    pv = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pv = 1'b0;
      end else begin
        if (x_valid && !pv) begin
          if (q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_x_valid: got x_out=%0d expected no output", x_out);
          end else begin
            chk("latency", cyc - q[0].acc, q[0].lat);
          end
        end
        if (x_valid && x_ready && q.size() != 0) begin
          e = q.pop_front();
          chk("x_out",   int'(x_out),   int'(e.x));
          chk("x_sat",   int'(x_sat),   int'(e.sat));
          chk("div_err", int'(div_err), int'(e.err));
        end
        pv = x_valid;
      end
    end
  end

  initial begin
    int hs;
    bit found;
    rst_n = 1'b0; y_valid = 1'b0; y_in = '0; b0 = '0; b1 = '0; a1 = '0; x_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("y_ready_in_reset", int'(y_ready), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_y_ready", int'(y_ready), 1);
    chk("rst_x_valid", int'(x_valid), 0);
    chk("rst_x_out",   int'(x_out),   0);
    chk("rst_x_sat",   int'(x_sat),   0);
    chk("rst_div_err", int'(div_err), 0);
    @(posedge clk); #1;

    // Low-pass reconstruction.
    scen1();
    drain(); do_reset();

    // Impulse response of b0=3,b1=3,a1=7 to a single x=5.
    sv(8'sd15, 4'sd3, 4'sd3, 4'sd7, 4'sd5, 1'b0, 1'b0);
    sv(8'sd21, 4'sd3, 4'sd3, 4'sd7, 4'sd0, 1'b0, 1'b0);
    sv(8'sd9,  4'sd3, 4'sd3, 4'sd7, 4'sd0, 1'b0, 1'b0);
    sv(8'sd3,  4'sd3, 4'sd3, 4'sd7, 4'sd0, 1'b0, 1'b0);
    sv(8'sd1,  4'sd3, 4'sd3, 4'sd7, 4'sd0, 1'b0, 1'b0);
    drain(); do_reset();

    // Saturation, signs, truncation toward zero, range edges.
    sv(8'sd100,   4'sd1,  4'sd0, 4'sd0, 4'sd7,  1'b1, 1'b0);
    sv(-8'sd100,  4'sd1,  4'sd0, 4'sd0, -4'sd8, 1'b1, 1'b0);
    sv(-8'sd128,  4'sd1,  4'sd0, 4'sd0, -4'sd8, 1'b1, 1'b0);
    sv(-8'sd128, -4'sd8,  4'sd0, 4'sd0, 4'sd7,  1'b1, 1'b0);
    sv(8'sd127,  -4'sd8,  4'sd0, 4'sd0, -4'sd8, 1'b1, 1'b0);
    sv(8'sd7,     4'sd2,  4'sd0, 4'sd0, 4'sd3,  1'b0, 1'b0);
    sv(-8'sd7,    4'sd2,  4'sd0, 4'sd0, -4'sd3, 1'b0, 1'b0);
    sv(-8'sd7,    4'sd3,  4'sd0, 4'sd0, -4'sd2, 1'b0, 1'b0);
    sv(8'sd7,     4'sd7,  4'sd0, 4'sd0, 4'sd1,  1'b0, 1'b0);
    sv(-8'sd8,    4'sd1,  4'sd0, 4'sd0, -4'sd8, 1'b0, 1'b0);
    sv(8'sd7,     4'sd1,  4'sd0, 4'sd0, 4'sd7,  1'b0, 1'b0);
    sv(8'sd8,     4'sd1,  4'sd0, 4'sd0, 4'sd7,  1'b1, 1'b0);
    sv(8'sd5,    -4'sd1,  4'sd0, 4'sd0, -4'sd5, 1'b0, 1'b0);

    // b0 = 0, then history must hold x_prev = 0; then a wrapping residual.
    sv(8'sd40,  4'sd0, 4'sd0,  4'sd0, 4'sd0,  1'b0, 1'b1);
    sv(8'sd3,   4'sd1, 4'sd1,  4'sd0, 4'sd3,  1'b0, 1'b0);
    sv(8'sd120, 4'sd1, -4'sd8, 4'sd0, -4'sd8, 1'b1, 1'b0);
    drain();

    // Backpressure: hold x_ready low 5 cycles with the next sample waiting.
    @(posedge clk); #1 x_ready = 1'b0;
    sv(8'sd100, 4'sd1, 4'sd0, 4'sd0, 4'sd7, 1'b1, 1'b0);
    hs = 0;
    fork
      sv(-8'sd100, 4'sd1, 4'sd0, 4'sd0, -4'sd8, 1'b1, 1'b0);
      begin
        found = 1'b0;
        for (int n = 0; n < 50 && !found; n++) begin
          @(negedge clk);
          if (x_valid) found = 1'b1;
        end
        if (!found) begin
          checks++; errors++;
          $display("FAIL bp_valid_timeout: got x_valid=0 expected 1");
        end
        for (int k = 0; k < 5; k++) begin
          chk("bp_x_out",   int'(x_out),   7);
          chk("bp_x_sat",   int'(x_sat),   1);
          chk("bp_div_err", int'(div_err), 0);
          chk("bp_x_valid", int'(x_valid), 1);
          chk("bp_y_ready", int'(y_ready), 0);
          @(negedge clk);
        end
        @(posedge clk); #1 x_ready = 1'b1;
        @(negedge clk);
        hs = cyc + 1;
      end
    join
    chk("bp_held_accept_edge", last_acc, hs + 1);
    drain(); do_reset();

    // Reset during DIV, then the low-pass run must repeat exactly.
    scen1();
    drain();
    send(8'sd18, 4'sd3, 4'sd0, 4'sd4, 4'sd0, 1'b0, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("abort_x_valid", int'(x_valid), 0);
    chk("abort_y_ready", int'(y_ready), 1);
    chk("abort_x_out",   int'(x_out),   0);
    @(posedge clk); #1;
    scen1();
    drain();

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
